// File: rtl/conv_pool_engine.sv
// conv_pool_engine
//
// Reads a square 2^IMG_LOG2 x 2^IMG_LOG2 grayscale image from the image ROM.
// For each of NUM_K kernels it computes a zero-padded 3x3 convolution with
// bias, round-half-up, ReLU and positive saturation. Each result map is
// written to its own layer-0 bank. When POOL_EN is set, the engine then
// reads that map back and writes a 2x2 / stride-2 max-pooled layer-1 map.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   ready             job request, sampled only while idle
//   busy              high from job acceptance until the last write is done
//   iaddr / idata     image ROM address (row*N+col) and returned pixel
//   cwr               layer-memory write strobe, one cycle per word
//   caddr_wr          layer-memory write address
//   cdata_wr          layer-memory write data
//   crd               layer-memory read strobe
//   caddr_rd          layer-memory read address
//   cdata_rd          layer-memory read data
//   csel              bank select: 1+k layer-0, 3+k layer-1, 0 none
module conv_pool_engine #(
  parameter int IMG_LOG2 = 6,
  parameter int DW       = 20,
  parameter int FRAC     = 16,
  parameter int NUM_K    = 2,
  parameter int POOL_EN  = 1,
  parameter logic [NUM_K*9*DW-1:0] KERNELS = '0,
  parameter logic [NUM_K*DW-1:0]   BIASES  = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    busy,
  input  logic                    ready,
  output logic [2*IMG_LOG2-1:0]   iaddr,
  input  logic [DW-1:0]           idata,
  output logic                    cwr,
  output logic [2*IMG_LOG2-1:0]   caddr_wr,
  output logic [DW-1:0]           cdata_wr,
  output logic                    crd,
  output logic [2*IMG_LOG2-1:0]   caddr_rd,
  input  logic [DW-1:0]           cdata_rd,
  output logic [2:0]              csel
);

  localparam int AW    = 2 * IMG_LOG2;
  localparam int PW    = AW - 2;
  localparam int ACC_W = 2 * DW + 4;

  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) <<< (FRAC - 1);
  localparam logic signed [ACC_W-1:0] MAX_POS = (ACC_W'(1) <<< (DW - 1)) - ACC_W'(1);
  localparam logic [DW-1:0]           MAX_OUT = {1'b0, {(DW-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, FETCH, CWR, PRD, PWR, DONE} state_t;

  state_t                    state;
  logic                      k;
  logic [AW-1:0]             pix;
  logic [3:0]                tap;
  logic signed [ACC_W-1:0]   acc;
  logic [PW-1:0]             pidx;
  logic [1:0]                sub;
  logic signed [DW-1:0]      pool_max;

  logic [IMG_LOG2-1:0]       row;
  logic [IMG_LOG2-1:0]       col;
  logic [AW-1:0]             pix_inc;
  logic [AW:0]               cur_tap;
  logic [AW:0]               next_tap;
  logic [AW:0]               next_pix_tap0;
  logic signed [DW-1:0]      w_cur;
  logic signed [DW-1:0]      bias_cur;
  logic signed [2*DW-1:0]    prod;
  logic signed [ACC_W-1:0]   term;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   scaled;
  logic [DW-1:0]             conv_result;
  logic signed [DW-1:0]      max_next;
  logic                      last_k;
  logic [2:0]                conv_bank;
  logic [2:0]                pool_bank;

  // Neighbour address for tap t of pixel (r,c); MSB flags "inside the image".
  function automatic logic [AW:0] tap_addr(input logic [IMG_LOG2-1:0] r,
                                           input logic [IMG_LOG2-1:0] c,
                                           input logic [3:0]          t);
    logic                ok;
    logic [IMG_LOG2-1:0] rr;
    logic [IMG_LOG2-1:0] cc;
    ok = 1'b1;
    rr = r;
    cc = c;
    case (t)
      4'd0, 4'd1, 4'd2: begin ok = ok & (r != '0); rr = r - IMG_LOG2'(1); end
      4'd6, 4'd7, 4'd8: begin ok = ok & (r != '1); rr = r + IMG_LOG2'(1); end
      default: ;
    endcase
    case (t)
      4'd0, 4'd3, 4'd6: begin ok = ok & (c != '0); cc = c - IMG_LOG2'(1); end
      4'd2, 4'd5, 4'd8: begin ok = ok & (c != '1); cc = c + IMG_LOG2'(1); end
      default: ;
    endcase
    return {ok, rr, cc};
  endfunction

  // Layer-0 address of sub-position s = {a,b} inside pooling window p = {i,j}.
  // Concatenating {i,a} and {j,b} gives row 2i+a and column 2j+b.
  function automatic logic [AW-1:0] pool_addr(input logic [PW-1:0] p,
                                               input logic [1:0]    s);
    return {p[PW-1:IMG_LOG2-1], s[1], p[IMG_LOG2-2:0], s[0]};
  endfunction

  assign row       = pix[AW-1:IMG_LOG2];
  assign col       = pix[IMG_LOG2-1:0];
  assign last_k    = (int'(k) == NUM_K - 1);
  assign conv_bank = 3'd1 + {2'b00, k};
  assign pool_bank = 3'd3 + {2'b00, k};

  // Datapath: MAC of the current tap, the post-processing applied on tap 8,
  // and the running maximum of the pooling window.
  always_comb begin
    pix_inc       = pix + AW'(1);
    cur_tap       = tap_addr(row, col, tap);
    next_tap      = tap_addr(row, col, tap + 4'd1);
    next_pix_tap0 = tap_addr(pix_inc[AW-1:IMG_LOG2], pix_inc[IMG_LOG2-1:0], 4'd0);

    w_cur    = KERNELS[(int'(k) * 9 + int'(tap)) * DW +: DW];
    bias_cur = BIASES[int'(k) * DW +: DW];
    prod     = $signed(idata) * w_cur;

    // Out-of-range neighbours contribute nothing (zero padding).
    term = '0;
    if (cur_tap[AW]) term = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};

    acc_next = term;
    if (tap != 4'd0) acc_next = acc + term;

    sum    = acc_next + ({{(ACC_W-DW){bias_cur[DW-1]}}, bias_cur} <<< FRAC) + HALF;
    scaled = sum >>> FRAC;

    conv_result = scaled[DW-1:0];
    if (scaled < 0)            conv_result = '0;
    else if (scaled > MAX_POS) conv_result = MAX_OUT;

    max_next = pool_max;
    if (sub == 2'd0 || $signed(cdata_rd) > pool_max) max_next = $signed(cdata_rd);
  end

  // Control FSM; every output is a register so strobes line up with the
  // address/data they qualify.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      iaddr    <= '0;
      cwr      <= 1'b0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      crd      <= 1'b0;
      caddr_rd <= '0;
      csel     <= '0;
      k        <= 1'b0;
      pix      <= '0;
      tap      <= '0;
      acc      <= '0;
      pidx     <= '0;
      sub      <= '0;
      pool_max <= '0;
    end else begin
      cwr <= 1'b0;
      crd <= 1'b0;
      case (state)
        IDLE: begin
          if (ready) begin
            busy  <= 1'b1;
            k     <= 1'b0;
            pix   <= '0;
            tap   <= '0;
            state <= FETCH;
          end
        end

        FETCH: begin
          acc <= acc_next;
          if (tap == 4'd8) begin
            cdata_wr <= conv_result;
            caddr_wr <= pix;
            csel     <= conv_bank;
            cwr      <= 1'b1;
            state    <= CWR;
          end else begin
            tap <= tap + 4'd1;
            // iaddr keeps its old value when the next neighbour is padding.
            if (next_tap[AW]) iaddr <= next_tap[AW-1:0];
          end
        end

        CWR: begin
          if (pix != '1) begin
            pix   <= pix_inc;
            tap   <= '0;
            state <= FETCH;
            if (next_pix_tap0[AW]) iaddr <= next_pix_tap0[AW-1:0];
          end else if (POOL_EN != 0) begin
            pidx     <= '0;
            sub      <= '0;
            crd      <= 1'b1;
            caddr_rd <= pool_addr('0, 2'd0);
            csel     <= conv_bank;
            state    <= PRD;
          end else if (!last_k) begin
            k     <= k + 1'b1;
            pix   <= '0;
            tap   <= '0;
            state <= FETCH;
          end else begin
            state <= DONE;
          end
        end

        PRD: begin
          pool_max <= max_next;
          if (sub == 2'd3) begin
            cdata_wr <= max_next;
            caddr_wr <= {2'b00, pidx};
            csel     <= pool_bank;
            cwr      <= 1'b1;
            state    <= PWR;
          end else begin
            sub      <= sub + 2'd1;
            crd      <= 1'b1;
            caddr_rd <= pool_addr(pidx, sub + 2'd1);
          end
        end

        PWR: begin
          if (pidx != '1) begin
            pidx     <= pidx + PW'(1);
            sub      <= '0;
            crd      <= 1'b1;
            caddr_rd <= pool_addr(pidx + PW'(1), 2'd0);
            csel     <= conv_bank;
            state    <= PRD;
          end else if (!last_k) begin
            k     <= k + 1'b1;
            pix   <= '0;
            tap   <= '0;
            state <= FETCH;
          end else begin
            state <= DONE;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
